// File: rtl/ev21g1_sequencer_if.sv
// Host/loader <-> microprogram sequencer bus: micro-store programming, run control
// and the registered {k, microinstruction} stream presented to the ev21g1 core.
interface ev21g1_sequencer_if #(
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = 2 + AW + 16 + 30;

    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [WW-1:0] prog_data;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [7:0]    loop_count;
    logic          halt_req;
    logic [15:0]   k;
    logic [29:0]   microinstruction;
    logic          busy;
    logic          done;

    modport master (
        output prog_we, prog_addr, prog_data, start, start_addr, loop_count, halt_req,
        input  k, microinstruction, busy, done
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, start_addr, loop_count, halt_req,
        output k, microinstruction, busy, done
    );
endinterface

// File: rtl/ev21g1_sequencer.sv
// Microprogram sequencer: writable micro-store plus a run FSM issuing one word per clock,
// with jumps, a counted loop, halt and automatic NOP gaps after memory reads.
module ev21g1_sequencer #(
    parameter int DEPTH    = 64,
    parameter int READ_GAP = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 srst,
    ev21g1_sequencer_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = 2 + AW + 16 + 30;
    localparam int GW = (READ_GAP < 2) ? 1 : $clog2(READ_GAP + 1);

    localparam logic [29:0] NOP_MI  = 30'h3F8000FC;
    localparam logic [1:0]  OP_SEQ  = 2'b00;
    localparam logic [1:0]  OP_JMP  = 2'b01;
    localparam logic [1:0]  OP_LOOP = 2'b10;
    localparam logic [1:0]  OP_HALT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state_r;
    logic [AW-1:0] pc_r;
    logic [7:0]    lcnt_r;
    logic [GW-1:0] gcnt_r;
    logic          gap_halt_r;
    logic [15:0]   k_r;
    logic [29:0]   mi_r;
    logic          busy_r;
    logic          done_r;

    logic [WW-1:0] mem_r [DEPTH];

    logic [WW-1:0] word_s;
    logic [1:0]    op_s;
    logic [AW-1:0] target_s;
    logic [15:0]   wk_s;
    logic [29:0]   wmi_s;
    logic          rd_s;
    logic [AW-1:0] pc_inc_s;
    logic [AW-1:0] pc_next_s;
    logic [7:0]    lcnt_next_s;

    // Decode the word at pc and work out where execution goes after it issues
    always_comb begin
        word_s      = mem_r[pc_r];
        op_s        = word_s[WW-1 -: 2];
        target_s    = word_s[46 +: AW];
        wk_s        = word_s[30 +: 16];
        wmi_s       = word_s[0 +: 30];
        rd_s        = wmi_s[21];
        pc_inc_s    = (pc_r == AW'(DEPTH - 1)) ? {AW{1'b0}} : pc_r + AW'(1);
        pc_next_s   = pc_inc_s;
        lcnt_next_s = lcnt_r;
        case (op_s)
            OP_SEQ:  pc_next_s = pc_inc_s;
            OP_JMP:  pc_next_s = target_s;
            OP_LOOP: begin
                if (lcnt_r != 8'd0) begin
                    pc_next_s   = target_s;
                    lcnt_next_s = lcnt_r - 8'd1;
                end else begin
                    pc_next_s   = pc_inc_s;
                end
            end
            OP_HALT: pc_next_s = pc_inc_s;
            default: pc_next_s = pc_inc_s;
        endcase
    end

    // Micro-store writes; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (state_r == S_IDLE && bus.prog_we) begin
            mem_r[bus.prog_addr] <= bus.prog_data;
        end
    end

    // Run FSM with registered k/microinstruction/busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            pc_r       <= {AW{1'b0}};
            lcnt_r     <= 8'd0;
            gcnt_r     <= {GW{1'b0}};
            gap_halt_r <= 1'b0;
            k_r        <= 16'h0000;
            mi_r       <= NOP_MI;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (srst) begin
            state_r    <= S_IDLE;
            pc_r       <= {AW{1'b0}};
            lcnt_r     <= 8'd0;
            gcnt_r     <= {GW{1'b0}};
            gap_halt_r <= 1'b0;
            k_r        <= 16'h0000;
            mi_r       <= NOP_MI;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    k_r    <= 16'h0000;
                    mi_r   <= NOP_MI;
                    // A run that ended normally left busy high; this is the closing NOP cycle
                    done_r <= busy_r;
                    busy_r <= 1'b0;
                    if (bus.start) begin
                        pc_r    <= bus.start_addr;
                        lcnt_r  <= bus.loop_count;
                        state_r <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.halt_req) begin
                        k_r     <= 16'h0000;
                        mi_r    <= NOP_MI;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        gcnt_r  <= {GW{1'b0}};
                        state_r <= S_IDLE;
                    end else begin
                        k_r    <= wk_s;
                        mi_r   <= wmi_s;
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                        pc_r   <= pc_next_s;
                        lcnt_r <= lcnt_next_s;
                        if (rd_s && (READ_GAP > 0)) begin
                            gcnt_r     <= GW'(READ_GAP);
                            gap_halt_r <= (op_s == OP_HALT);
                            state_r    <= S_GAP;
                        end else if (op_s == OP_HALT) begin
                            state_r <= S_IDLE;
                        end else begin
                            state_r <= S_RUN;
                        end
                    end
                end
                S_GAP: begin
                    k_r  <= 16'h0000;
                    mi_r <= NOP_MI;
                    if (bus.halt_req) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        gcnt_r  <= {GW{1'b0}};
                        state_r <= S_IDLE;
                    end else begin
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                        gcnt_r <= gcnt_r - GW'(1);
                        if (gcnt_r <= GW'(1)) begin
                            state_r <= gap_halt_r ? S_IDLE : S_RUN;
                        end else begin
                            state_r <= S_GAP;
                        end
                    end
                end
                default: begin
                    k_r     <= 16'h0000;
                    mi_r    <= NOP_MI;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.k                = k_r;
    assign bus.microinstruction = mi_r;
    assign bus.busy             = busy_r;
    assign bus.done             = done_r;
endmodule

// File: tb/tb_ev21g1_sequencer.sv
// Scoreboard bench for ev21g1_sequencer: a stream-level reference model pushes expected
// output cycles; an independent negedge monitor pops and compares them.
module tb_ev21g1_sequencer;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  localparam int WW = 54;
  localparam int READ_GAP = 2;
  localparam logic [29:0] NOP = 30'h3F8000FC;

  typedef struct packed {
    logic [15:0] k;
    logic [29:0] mi;
    logic        busy;
    logic        done;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic srst = 1'b0;
  always #5 clk = ~clk;

  ev21g1_sequencer_if #(.DEPTH(DEPTH)) bus();
  ev21g1_sequencer #(.DEPTH(DEPTH), .READ_GAP(READ_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .srst(srst), .bus(bus));

  obs_t exp_q[$];
  logic [WW-1:0] model_mem [DEPTH];
  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  obs_t got;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [29:0] mkmi(input logic [3:0] aluc, input logic [2:0] sh, input logic kmx,
                                       input logic rd, input logic wr, input logic [5:0] a,
                                       input logic [5:0] b, input logic [5:0] c);
    return {aluc, sh, kmx, rd, wr, a, b, c, 1'b0, 1'b0};
  endfunction

  // Monitor: every cycle that claims busy/done consumes one expected entry; other cycles must be idle NOP
  always @(negedge clk) begin
    got = {bus.k, bus.microinstruction, bus.busy, bus.done};
    if (!rst_n) check("reset_out", got, {16'h0000, NOP, 1'b0, 1'b0});
    else if (got.busy || got.done) begin
      if (got.busy) busy_cnt++;
      if (exp_q.size() == 0) check("unexpected_out", got, {16'h0000, NOP, 1'b0, 1'b0});
      else check("stream", got, exp_q.pop_front());
    end else check("idle_nop", got, {16'h0000, NOP, 1'b0, 1'b0});
  end

  task automatic wr(input int addr, input logic [WW-1:0] w);
    @(negedge clk);
    bus.prog_we = 1'b1; bus.prog_addr = AW'(addr); bus.prog_data = w;
    @(negedge clk);
    bus.prog_we = 1'b0;
    model_mem[addr] = w;
  endtask

  // Reference: walk the program by opcode rules, emitting one entry per output cycle
  task automatic model_run(input int sa, input int lc, input int abort_at, output int n);
    obs_t lst[$];
    int pc = sa;
    int l = lc;
    logic [WW-1:0] w;
    for (int guard = 0; guard < 1000; guard++) begin
      w = model_mem[pc];
      lst.push_back({w[45:30], w[29:0], 1'b1, 1'b0});
      if (w[21]) repeat (READ_GAP) lst.push_back({16'h0000, NOP, 1'b1, 1'b0});
      if (w[53:52] == 2'd3) break;
      else if (w[53:52] == 2'd1) pc = int'(w[51:46]);
      else if (w[53:52] == 2'd2 && l != 0) begin l--; pc = int'(w[51:46]); end
      else pc = (pc + 1) % DEPTH;
    end
    if (abort_at >= 0) while (lst.size() > abort_at) void'(lst.pop_back());
    lst.push_back({16'h0000, NOP, 1'b0, 1'b1});
    n = lst.size();
    foreach (lst[i]) exp_q.push_back(lst[i]);
  endtask

  task automatic run(input int sa, input int lc, input int abort_at, input bit disturb,
                     input bit co_write, input logic [WW-1:0] co_word);
    int n;
    if (co_write) model_mem[sa] = co_word;
    model_run(sa, lc, abort_at, n);
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = AW'(sa); bus.loop_count = 8'(lc);
    bus.prog_we = co_write; bus.prog_addr = AW'(sa); bus.prog_data = co_word;
    for (int i = 1; i <= n + 3; i++) begin
      @(negedge clk);
      bus.start = disturb && (i == 2);
      bus.start_addr = disturb ? AW'(sa + 3) : AW'(sa);
      bus.prog_we = disturb && (i == 2);
      bus.prog_addr = AW'(sa);
      bus.prog_data = {$urandom(), $urandom()};
      bus.halt_req = (i == abort_at + 1);
    end
    bus.start = 1'b0; bus.prog_we = 1'b0; bus.halt_req = 1'b0;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    int base;
    int len;
    int r;
    int tgt;
    logic [1:0] op;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0; bus.start = 1'b0;
    bus.start_addr = '0; bus.loop_count = 8'd0; bus.halt_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_k", 64'(bus.k), 64'h0);
    check("rst_mi", 64'(bus.microinstruction), 64'(NOP));
    check("rst_busy_done", 64'({bus.busy, bus.done}), 64'h0);
    rst_n = 1'b1;

    // Linear program with a read+HALT at the end
    wr(0, {2'd0, 6'd0, 16'h00AA, mkmi(4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0)});
    wr(1, {2'd0, 6'd0, 16'h00BB, mkmi(4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd1)});
    wr(2, {2'd0, 6'd0, 16'h0000, mkmi(4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 6'd1, 6'd0, 6'd0)});
    wr(3, {2'd3, 6'd0, 16'h0000, mkmi(4'd0, 3'd0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd2)});
    busy_cnt = 0;
    run(0, 0, -1, 1'b0, 1'b0, '0);
    check("busy_cycles", 64'(busy_cnt), 64'd6);

    // Counted loop
    wr(5, {2'd0, 6'd0,  16'h0011, mkmi(4'd1, 3'd0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd3)});
    wr(6, {2'd2, 6'd5,  16'h0066, mkmi(4'd2, 3'd0, 1'b0, 1'b0, 1'b0, 6'd1, 6'd2, 6'd3)});
    wr(7, {2'd3, 6'd0,  16'h0077, mkmi(4'd3, 3'd0, 1'b0, 1'b0, 1'b0, 6'd4, 6'd5, 6'd6)});
    run(5, 2, -1, 1'b0, 1'b0, '0);

    // Wrap 63 -> 0 then jump
    wr(63, {2'd0, 6'd0,  16'h0063, mkmi(4'd4, 3'd1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0)});
    wr(0,  {2'd1, 6'd10, 16'h0100, mkmi(4'd5, 3'd2, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0)});
    wr(10, {2'd3, 6'd0,  16'h0010, mkmi(4'd6, 3'd3, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0)});
    run(63, 0, -1, 1'b0, 1'b0, '0);

    // halt_req during the second gap NOP after a read
    wr(20, {2'd0, 6'd0, 16'h2020, mkmi(4'd7, 3'd0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd1, 6'd2)});
    wr(21, {2'd0, 6'd0, 16'h2121, mkmi(4'd8, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd1, 6'd2)});
    wr(22, {2'd3, 6'd0, 16'h2222, mkmi(4'd9, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd1, 6'd2)});
    run(20, 0, 3, 1'b0, 1'b0, '0);
    // halt_req coinciding with the HALT word itself
    run(20, 0, 4, 1'b0, 1'b0, '0);

    // prog_we and start while busy are ignored; rerun shows original program
    run(5, 2, -1, 1'b1, 1'b0, '0);
    run(5, 2, -1, 1'b0, 1'b0, '0);

    // Write together with start at the same address
    run(63, 0, -1, 1'b0, 1'b1, {2'd3, 6'd0, 16'h1234, mkmi(4'd2, 3'd4, 1'b1, 1'b0, 1'b0, 6'd9, 6'd8, 6'd7)});

    // Asynchronous reset mid-run
    model_run(5, 2, -1, n);
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = AW'(5); bus.loop_count = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mi", 64'(bus.microinstruction), 64'(NOP));
    check("async_rst_k_busy_done", 64'({bus.k, bus.busy, bus.done}), 64'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run(5, 2, -1, 1'b0, 1'b0, '0);

    // Randomized terminating programs: forward jumps, backward loops, HALT at the end
    for (int t = 0; t < 25; t++) begin
      base = int'($urandom_range(0, 63));
      len = int'($urandom_range(2, 8));
      for (int i = 0; i < len; i++) begin
        r = int'($urandom_range(0, 9));
        tgt = 0;
        if (i == len - 1 || r == 9) op = 2'd3;
        else if (r == 7) begin op = 2'd1; tgt = int'($urandom_range(i + 1, len - 1)); end
        else if (r == 8) begin op = 2'd2; tgt = int'($urandom_range(0, i)); end
        else op = 2'd0;
        wr((base + i) % DEPTH, {op, 6'((base + tgt) % DEPTH), 16'($urandom()), 30'($urandom())});
      end
      run(base, int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : -1,
          1'b0, 1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ev21g1_sequencer.md
# ev21g1_sequencer

Microprogram sequencer that drives the ev21g1 datapath's `k` and `microinstruction` inputs. It replaces hand-sequenced microinstruction streams. A small writable micro-store holds the program, and a run FSM issues one microinstruction per clock. It supports jumps, a counted loop and halt, and automatically inserts NOP cycles after memory reads to cover the load-use latency. It sits between the host/loader and the ev21g1 core.

## Interface
- `DEPTH`, 64: micro-store words; `AW = $clog2(DEPTH)`.
- `READ_GAP`, 2: NOP cycles inserted after any issued word with read=1 (0 allowed).
- Word format (`WW = 2+AW+16+30`): `{op[1:0], target[AW-1:0], k[15:0], mi[29:0]}`. `mi` layout: aluc[29:26], sh[25:23], kmx[22], read[21], write[20], a[19:14], b[13:8], c[7:2], flip[1], print[0].
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  reset. Asynchronous assertion, active-low.
- `prog_we`  in  1  micro-store write strobe. Honoured only in IDLE.
- `prog_addr`  in  AW  micro-store write address.
- `prog_data`  in  WW  micro-store write data.
- `start`  in  1  begin execution. Sampled only in IDLE.
- `start_addr`  in  AW  first word to issue.
- `loop_count`  in  8  initial loop counter, latched on start.
- `halt_req`  in  1  abort request while busy.
- `k`  out  16  registered constant to core.
- `microinstruction`  out  30  registered microinstruction to core.
- `busy`  out  1  high in RUN/GAP.
- `done`  out  1  one-cycle pulse on return to IDLE.

## Operation
- NOP is `mi` = 30'h3F8000FC (aluc=1111, sh=111, c=111111, all other fields 0), issued with `k` = 0.
- Opcodes, applied after the word is issued:
  - SEQ(00): `pc` ← `pc`+1, modulo DEPTH (wraps 63→0).
  - JMP(01): `pc` ← `target`.
  - LOOP(10): if `lcnt` ≠ 0, then `lcnt` ← `lcnt`−1 and `pc` ← `target`; else `pc` ← `pc`+1.
  - HALT(11): the word is issued, then the run ends.
- FSM states:
  - IDLE: outputs NOP.
    - On `start`, latch `pc` ← `start_addr` and `lcnt` ← `loop_count`, then go to RUN.
    - On `prog_we`, write `mem[prog_addr]`.
  - RUN: each cycle, register `{k, mi}` ← `mem[pc]` and advance `pc` per the opcode.
    - If the issued word has read=1 and READ_GAP>0, go to GAP with `gcnt` ← READ_GAP.
    - Otherwise, on HALT go to IDLE.
  - GAP: outputs NOP; `gcnt` decrements each cycle.
    - When the last NOP has issued, return to RUN, or to IDLE if the triggering word was HALT.
- Write words (write=1) get no gap. Back-to-back writes and write-then-read issue consecutively.
- `halt_req` in RUN or GAP: the next registered output is NOP and the FSM goes to IDLE, with `done` pulsing. Any pending gap is discarded.
- `halt_req` and HALT in the same cycle: the HALT word is not issued; output is NOP.
- `prog_we` and `start` are ignored while `busy`.
- `prog_we` together with `start` in IDLE: the write happens and the run starts. The written word is visible if `prog_addr` == `start_addr`.
- Reset does not clear micro-store contents. All other state resets.

## Timing
- Reset values: `microinstruction` = 30'h3F8000FC, `k` = 0, `busy` = 0, `done` = 0. FSM = IDLE, `pc` = 0, `lcnt` = 0, `gcnt` = 0.
- Reset assertion mid-run forces the reset values immediately, with no `done` pulse.
- `start` sampled at edge N: `mem[start_addr]` appears on the outputs after edge N+1. `busy` is high from N+1.
- Throughput is one word per cycle, plus READ_GAP cycles per read.
- Final word issued at edge M: outputs are NOP at edge M+1 (plus gap cycles). `done` = 1 and `busy` = 0 in that same cycle.
- The micro-store read is combinational into the output register. There is no fetch bubble after JMP or LOOP.

## Test plan
- Linear program, READ_GAP=2, words at 0..3:
  - Words: k=00AA→c=0 (kmx=1), k=00BB→c=1, write (a=1, b=0), read (b=0, c=2, HALT).
  - Start at 0. Required output stream: 4 words, then NOP, NOP, then NOP with `done`=1.
  - `busy` is high for exactly 6 cycles.
- Loop: word 5 = SEQ k=0011, word 6 = LOOP target=5, word 7 = HALT; `loop_count`=2.
  - Required issue order: 5,6,5,6,5,6,7. `done` pulses 1 cycle after word 7.
- Wrap and jump: word 63 = SEQ, word 0 = JMP target 10, word 10 = HALT; start at 63.
  - Required issue order: 63, 0, 10.
- `halt_req` asserted during the second gap NOP following a read: the next output is NOP, `done`=1, `busy`=0. The following word is never issued.
- Attempt `prog_we` to the running address, and a second `start`, while busy: no effect. A rerun shows the original contents and the original start address.
- Assert `rst_n`=0 mid-run: outputs go to NOP/0 asynchronously. After release, a restart issues unchanged micro-store contents.
